// File: rtl/train_sequencer_if.sv
// Control/status bundle for train_sequencer.
//   master (sequencer side): receives enable/start, drives all strobes, indices and status.
//   slave  (consumer side) : drives enable/start, observes everything else.
// Signals:
//   enable, start        - run permission and run request
//   w_layer_index [31:0] - layer index for weight load/backprop
//   w_row_index   [31:0] - row index for weight load/backprop
//   epoch_index   [31:0] - current epoch, 0-based
//   is_load, load_w, is_update, i_is_load, use_z, backprop_cost, is_cost_layer - phase strobes
//   busy, done           - status
interface train_sequencer_if;
  logic        enable;
  logic        start;
  logic [31:0] w_layer_index;
  logic [31:0] w_row_index;
  logic [31:0] epoch_index;
  logic        is_load;
  logic        load_w;
  logic        is_update;
  logic        i_is_load;
  logic        use_z;
  logic        backprop_cost;
  logic        is_cost_layer;
  logic        busy;
  logic        done;

  modport master (
    input  enable, start,
    output w_layer_index, w_row_index, epoch_index,
    output is_load, load_w, is_update, i_is_load, use_z,
    output backprop_cost, is_cost_layer, busy, done
  );

  modport slave (
    output enable, start,
    input  w_layer_index, w_row_index, epoch_index,
    input  is_load, load_w, is_update, i_is_load, use_z,
    input  backprop_cost, is_cost_layer, busy, done
  );
endinterface

// File: rtl/train_sequencer.sv
// Training sequencer for a systolic array: per epoch, each layer goes through weight load
// (LOAD_W), feed (FEED) and pipeline drain (DRAIN); the epoch closes with a cost backprop
// phase (COST). After the last epoch a one-cycle DONE state pulses done.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high; forces IDLE and clears all counters
//   bus   - train_sequencer_if.master (enable/start in, strobes/indices/status out)
// Parameters: SIZE (rows per layer), LAYER_COUNT (layers per epoch), EPOCH_COUNT (epochs/run).
// Build option: define TRAIN_SEQUENCER_PAUSE_EN to make enable=0 while busy pause the
// sequence (state and counters frozen, strobes forced low) instead of aborting it.
module train_sequencer #(
  parameter int unsigned SIZE        = 3,
  parameter int unsigned LAYER_COUNT = 2,
  parameter int unsigned EPOCH_COUNT = 3
) (
  input logic               clk,
  input logic               reset,
  train_sequencer_if.master bus
);

  localparam logic [31:0] RowLast   = 32'(SIZE - 1);
  localparam logic [31:0] DrainLast = 32'(2 * SIZE + 2);
  localparam logic [31:0] LayerLast = 32'(LAYER_COUNT - 1);
  localparam logic [31:0] EpochLast = 32'(EPOCH_COUNT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StFeed,
    StDrain,
    StCost,
    StDone
  } state_e;

  state_e      state_q, state_d;
  // row_q doubles as the in-phase cycle counter (DRAIN counts past SIZE but never drives
  // the row index).
  logic [31:0] row_q, row_d;
  logic [31:0] layer_q, layer_d;
  logic [31:0] epoch_q, epoch_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      row_q   <= '0;
      layer_q <= '0;
      epoch_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      layer_q <= layer_d;
      epoch_q <= epoch_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    layer_d = layer_q;
    epoch_d = epoch_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start && bus.enable) begin
          state_d = StLoadW;
          row_d   = '0;
          layer_d = '0;
          epoch_d = '0;
        end
      end
      StLoadW: begin
        if (row_q == RowLast) begin
          state_d = StFeed;
          row_d   = '0;
        end else begin
          row_d = row_q + 32'd1;
        end
      end
      StFeed: begin
        if (row_q == RowLast) begin
          state_d = StDrain;
          row_d   = '0;
        end else begin
          row_d = row_q + 32'd1;
        end
      end
      StDrain: begin
        if (row_q == DrainLast) begin
          row_d = '0;
          if (layer_q < LayerLast) begin
            state_d = StLoadW;
            layer_d = layer_q + 32'd1;
          end else begin
            state_d = StCost;
          end
        end else begin
          row_d = row_q + 32'd1;
        end
      end
      StCost: begin
        if (row_q == RowLast) begin
          row_d = '0;
          if (epoch_q < EpochLast) begin
            state_d = StLoadW;
            layer_d = '0;
            epoch_d = epoch_q + 32'd1;
          end else begin
            state_d = StDone;
          end
        end else begin
          row_d = row_q + 32'd1;
        end
      end
      StDone: begin
        state_d = StIdle;
        row_d   = '0;
        layer_d = '0;
      end
      default: begin
        state_d = StIdle;
        row_d   = '0;
        layer_d = '0;
      end
    endcase

    // Losing enable mid-run overrides the normal sequencing.
    if (state_q != StIdle && !bus.enable) begin
`ifdef TRAIN_SEQUENCER_PAUSE_EN
      state_d = state_q;
      row_d   = row_q;
      layer_d = layer_q;
      epoch_d = epoch_q;
`else
      state_d = StIdle;
      row_d   = '0;
      layer_d = '0;
      epoch_d = epoch_q;
`endif
    end
  end

  // Output decode
  always_comb begin
    bus.is_load       = 1'b0;
    bus.load_w        = 1'b0;
    bus.is_update     = 1'b0;
    bus.i_is_load     = 1'b0;
    bus.use_z         = 1'b0;
    bus.backprop_cost = 1'b0;
    bus.is_cost_layer = 1'b0;
    bus.done          = 1'b0;
    bus.w_layer_index = '0;
    bus.w_row_index   = '0;
    bus.busy          = (state_q != StIdle);
    bus.epoch_index   = epoch_q;

    unique case (state_q)
      StLoadW: begin
        bus.is_load       = 1'b1;
        bus.load_w        = 1'b1;
        bus.w_layer_index = layer_q;
        bus.w_row_index   = row_q;
      end
      StFeed: begin
        bus.is_load       = 1'b1;
        bus.is_update     = 1'b1;
        bus.w_layer_index = layer_q;
        bus.w_row_index   = row_q;
        // First layer consumes fresh input data; later layers take the previous z.
        if (layer_q == '0) bus.i_is_load = 1'b1;
        else               bus.use_z     = 1'b1;
      end
      StCost: begin
        bus.backprop_cost = 1'b1;
        bus.use_z         = 1'b1;
        bus.is_cost_layer = 1'b1;
        bus.w_layer_index = LayerLast;
        bus.w_row_index   = row_q;
      end
      StDone: begin
        bus.done = 1'b1;
      end
      default: begin
      end
    endcase

`ifdef TRAIN_SEQUENCER_PAUSE_EN
    // While paused the indices and status hold; only the strobes drop.
    if (!bus.enable) begin
      bus.is_load       = 1'b0;
      bus.load_w        = 1'b0;
      bus.is_update     = 1'b0;
      bus.i_is_load     = 1'b0;
      bus.use_z         = 1'b0;
      bus.backprop_cost = 1'b0;
      bus.is_cost_layer = 1'b0;
      bus.done          = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_train_sequencer.sv
module tb_train_sequencer;

  localparam int unsigned SIZE        = 3;
  localparam int unsigned LAYER_COUNT = 2;
  localparam int unsigned EPOCH_COUNT = 3;

  typedef struct packed {
    logic        is_load;
    logic        load_w;
    logic        is_update;
    logic        i_is_load;
    logic        use_z;
    logic        backprop_cost;
    logic        is_cost_layer;
    logic        busy;
    logic        done;
    logic [31:0] layer;
    logic [31:0] row;
    logic [31:0] epoch;
  } vec_t;

  logic clk = 1'b0;
  logic reset;

  train_sequencer_if bus ();

  train_sequencer #(
    .SIZE       (SIZE),
    .LAYER_COUNT(LAYER_COUNT),
    .EPOCH_COUNT(EPOCH_COUNT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  vec_t sb[$];     // expected outputs, one per cycle
  vec_t plan[$];   // remaining states of the run in progress
  vec_t cur;       // model of the registered state
  bit   model_valid = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  function automatic vec_t idle_vec(input logic [31:0] ep);
    vec_t v;
    v = '0;
    v.epoch = ep;
    return v;
  endfunction

  // Whole run written out phase by phase from the cycle-count rules.
  function automatic void build_run();
    vec_t v;
    plan.delete();
    for (int e = 0; e < int'(EPOCH_COUNT); e++) begin
      for (int l = 0; l < int'(LAYER_COUNT); l++) begin
        for (int r = 0; r < int'(SIZE); r++) begin
          v = idle_vec(32'(e)); v.busy = 1; v.is_load = 1; v.load_w = 1;
          v.layer = 32'(l); v.row = 32'(r);
          plan.push_back(v);
        end
        for (int r = 0; r < int'(SIZE); r++) begin
          v = idle_vec(32'(e)); v.busy = 1; v.is_load = 1; v.is_update = 1;
          v.layer = 32'(l); v.row = 32'(r);
          if (l == 0) v.i_is_load = 1; else v.use_z = 1;
          plan.push_back(v);
        end
        for (int r = 0; r < int'(2 * SIZE + 3); r++) begin
          v = idle_vec(32'(e)); v.busy = 1;
          plan.push_back(v);
        end
      end
      for (int r = 0; r < int'(SIZE); r++) begin
        v = idle_vec(32'(e)); v.busy = 1; v.backprop_cost = 1; v.use_z = 1;
        v.is_cost_layer = 1; v.layer = 32'(LAYER_COUNT - 1); v.row = 32'(r);
        plan.push_back(v);
      end
    end
    v = idle_vec(32'(EPOCH_COUNT - 1)); v.busy = 1; v.done = 1;
    plan.push_back(v);
  endfunction

  function automatic vec_t gated(input vec_t v, input logic en);
    vec_t g;
    g = v;
`ifdef TRAIN_SEQUENCER_PAUSE_EN
    if (!en) begin
      g.is_load = 0; g.load_w = 0; g.is_update = 0; g.i_is_load = 0; g.use_z = 0;
      g.backprop_cost = 0; g.is_cost_layer = 0; g.done = 0;
    end
`endif
    return g;
  endfunction

  // Drive one cycle of inputs, queue the expected output, advance the model at the edge.
  task automatic step(input logic rst_v, input logic en_v, input logic st_v);
    vec_t nxt;
    reset = rst_v;
    bus.enable = en_v;
    bus.start = st_v;
    if (model_valid) sb.push_back(gated(cur, en_v));
    nxt = cur;
    if (rst_v) begin
      plan.delete();
      nxt = idle_vec('0);
    end else if (!model_valid) begin
      nxt = cur;
    end else if (cur.busy && !en_v) begin
`ifdef TRAIN_SEQUENCER_PAUSE_EN
      nxt = cur;
`else
      plan.delete();
      nxt = idle_vec(cur.epoch);
`endif
    end else if (!cur.busy) begin
      if (st_v && en_v) begin
        build_run();
        nxt = plan.pop_front();
      end
    end else if (plan.size() == 0) begin
      nxt = idle_vec(cur.epoch);
    end else begin
      nxt = plan.pop_front();
    end
    @(posedge clk);
    #1;
    cur = nxt;
    if (rst_v) model_valid = 1'b1;
  endtask

  // Monitor: every cycle with an expectation queued, compare the full output vector.
  always @(negedge clk) begin
    vec_t got, exp_v;
    cyc <= cyc + 1;
    if (sb.size() != 0) begin
      exp_v = sb.pop_front();
      got.is_load       = bus.is_load;
      got.load_w        = bus.load_w;
      got.is_update     = bus.is_update;
      got.i_is_load     = bus.i_is_load;
      got.use_z         = bus.use_z;
      got.backprop_cost = bus.backprop_cost;
      got.is_cost_layer = bus.is_cost_layer;
      got.busy          = bus.busy;
      got.done          = bus.done;
      got.layer         = bus.w_layer_index;
      got.row           = bus.w_row_index;
      got.epoch         = bus.epoch_index;
      vectors++;
      if (got !== exp_v) begin
        miscompares++;
        $display("FAIL outputs cyc=%0d: actual strobes=%b busy=%b done=%b layer=%0d row=%0d epoch=%0d, required strobes=%b busy=%b done=%b layer=%0d row=%0d epoch=%0d",
                 cyc,
                 {got.is_load, got.load_w, got.is_update, got.i_is_load, got.use_z,
                  got.backprop_cost, got.is_cost_layer}, got.busy, got.done,
                 got.layer, got.row, got.epoch,
                 {exp_v.is_load, exp_v.load_w, exp_v.is_update, exp_v.i_is_load, exp_v.use_z,
                  exp_v.backprop_cost, exp_v.is_cost_layer}, exp_v.busy, exp_v.done,
                 exp_v.layer, exp_v.row, exp_v.epoch);
      end
    end
  end

  initial begin
    cur = idle_vec('0);
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.start = 1'b0;

    // Reset, then idle with start held but enable low (must not launch or queue).
    step(1, 0, 0);
    step(1, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    step(0, 1, 0);

    // Full default run; extra start pulses mid-run must be ignored.
    step(0, 1, 1);
    for (int i = 0; i < 104; i++) step(0, 1, ($urandom_range(0, 4) == 0));

    // Reset during layer-1 FEED row 1, then a fresh full run.
    step(0, 1, 1);
    for (int i = 0; i < 19; i++) step(0, 1, 0);
    step(1, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0);
    step(0, 1, 1);
    for (int i = 0; i < 103; i++) step(0, 1, 0);

    // Enable dropped for 5 cycles inside layer-0 DRAIN.
    step(0, 1, 1);
    for (int i = 0; i < 7; i++) step(0, 1, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    for (int i = 0; i < 100; i++) step(0, 1, 0);

    // Random stress: mostly enabled, frequent start, occasional reset.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 24) != 0),
           ($urandom_range(0, 7) == 0));
    step(0, 1, 0);

    @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: actual %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: actual still running, required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/train_sequencer.md
TRAIN_SEQUENCER -- requirements
Module: train_sequencer

Interface
REQ-001 Parameter SIZE, default 3, meaning systolic row count and rows per layer.
REQ-002 Parameter LAYER_COUNT, default 2, meaning layers processed per epoch.
REQ-003 Parameter EPOCH_COUNT, default 3, meaning epochs per run.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 enable  input  1  run permission.
REQ-007 start  input  1  request a run; sampled only in IDLE.
REQ-008 w_layer_index  output  32  layer index for weight load/backprop.
REQ-009 w_row_index  output  32  row index for weight load/backprop.
REQ-010 is_load, load_w, is_update, i_is_load, use_z  outputs  1 each  weight fetch, weight-to-systolic, backprop advance, next data set, z-as-input strobes.
REQ-011 backprop_cost, is_cost_layer  outputs  1 each  cost backprop strobe, cost-layer flag.
REQ-012 epoch_index  output  32  current epoch, 0-based.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse at end of run.

Function
REQ-015 States: IDLE, LOAD_W, FEED, DRAIN, COST, DONE; outputs are a decode of registered state, layer counter, row counter and epoch counter.
REQ-016 IDLE -> LOAD_W when start=1 and enable=1; layer, row and epoch counters cleared on that edge.
REQ-017 LOAD_W lasts SIZE cycles: is_load=1, load_w=1, w_layer_index=layer, w_row_index=row (0..SIZE-1); then FEED with row=0.
REQ-018 FEED lasts SIZE cycles: is_load=1, is_update=1, w_layer_index=layer, w_row_index=row; i_is_load=1 if layer==0, else use_z=1; then DRAIN.
REQ-019 DRAIN lasts 2*SIZE+3 cycles with all strobes 0 and both indices 0; on its last cycle, layer<LAYER_COUNT-1 -> LOAD_W with layer+1, else COST.
REQ-020 COST lasts SIZE cycles: backprop_cost=1, use_z=1, is_cost_layer=1, w_layer_index=LAYER_COUNT-1, w_row_index=row.
REQ-021 COST last cycle: epoch<EPOCH_COUNT-1 -> LOAD_W with layer=0, epoch+1; else DONE.
REQ-022 DONE lasts one cycle with done=1, busy=1, all other strobes 0; then IDLE.
REQ-023 In IDLE all strobes, both indices, busy and done are 0; epoch_index holds its last value.
REQ-024 Row counter wraps to 0 on every phase exit; no counter ever exceeds its phase limit.
REQ-025 start while busy is ignored; start with enable=0 in IDLE is ignored, not queued.
REQ-026 Only one strobe group is active per cycle; is_cost_layer is 1 only in COST.
REQ-027 Per-epoch length = LAYER_COUNT*(4*SIZE+3)+SIZE cycles; full run = EPOCH_COUNT times that plus 1 (DONE).

Reset
REQ-028 reset=1 on a clock edge forces IDLE, clears all counters including epoch_index, all outputs 0 the following cycle.
REQ-029 reset has priority over enable and start, including mid-phase; no done pulse is generated by reset.

Configuration
REQ-030 Macro TRAIN_SEQUENCER_PAUSE_EN: when defined, enable=0 while busy freezes state and all counters and forces all strobes to 0 (indices, epoch_index and busy hold); enable=1 resumes the same cycle position.
REQ-031 Without TRAIN_SEQUENCER_PAUSE_EN, enable=0 while busy aborts: next state IDLE, counters cleared except epoch_index, no done pulse.

Verification
REQ-032 Defaults, start pulse with enable=1 -> busy high 100 cycles (99 run + DONE), done pulses exactly once at cycle 100 after start, epoch_index 0,1,2.
REQ-033 Defaults, observe epoch 0 -> load_w for 3 cycles rows 0,1,2 layer 0; i_is_load 3 cycles; 9 idle DRAIN cycles; layer 1 FEED uses use_z not i_is_load.
REQ-034 Defaults, COST phase -> backprop_cost and is_cost_layer high 3 cycles, w_layer_index=1, rows 0,1,2.
REQ-035 reset asserted during layer-1 FEED row 1 -> next cycle IDLE, all outputs 0, epoch_index 0, no done; new start runs full 100 cycles.
REQ-036 enable dropped 5 cycles during DRAIN: with macro -> strobes 0, total run extends to 105 cycles; without macro -> IDLE, no done.
REQ-037 start asserted repeatedly mid-run and with enable=0 in IDLE -> no restart, no state change.
